// File: rtl/toy_uart_pkg.sv
// rtl/toy_uart_pkg.sv - shared constants and receiver state encoding for the toy UART.
package toy_uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_BAUD_DIV = 2604;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/toy_rx_fifo.sv
// rtl/toy_rx_fifo.sv - show-ahead byte FIFO; a push while full is accepted only alongside a pop.
module toy_rx_fifo
  import toy_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_q;
  logic [AW-1:0]        rd_q;
  logic [AW:0]          cnt_q;
  logic                 do_push;
  logic                 do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_data  = o_empty ? '0 : mem_q[rd_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/toy_uart_rx.sv
// rtl/toy_uart_rx.sv - 8N1 UART receiver with valid/ready output buffer.
// TOY_UART_RX_FIFO_EN selects the FIFO_DEPTH FIFO; otherwise a single holding register.
module toy_uart_rx
  import toy_uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  if (BAUD_DIV < 4 || (BAUD_DIV % 2) != 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("toy_uart_rx: illegal BAUD_DIV or FIFO_DEPTH");
  end

  logic                 sync1_q;
  logic                 rxs_q;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 cnt_zero;
  logic                 push;
  logic                 pop;
  logic                 full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      rxs_q   <= sync1_q;
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign push     = (state_q == ST_STOP) && cnt_zero && rxs_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_q <= ST_START;
            cnt_q   <= HALF_M1;
          end
        end
        ST_START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rxs_q) begin
            state_q <= ST_DATA;
            cnt_q   <= FULL_M1;
            bit_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
            cnt_q   <= FULL_M1;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'(DATA_BITS - 1)) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs_q) begin
            state_q <= ST_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          // Hold off while the line stays low so a break yields a single error.
          if (rxs_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TOY_UART_RX_FIFO_EN
  logic empty;

  toy_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_data (shift_q),
    .i_pop  (pop),
    .o_data (o_data),
    .o_full (full),
    .o_empty(empty)
  );

  assign o_valid = ~empty;
  assign pop     = ~empty & i_ready;
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_v_q;

  assign full    = hold_v_q;
  assign pop     = hold_v_q & i_ready;
  assign o_valid = hold_v_q;
  assign o_data  = hold_v_q ? hold_q : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (push && (!hold_v_q || pop)) begin
      hold_q   <= shift_q;
      hold_v_q <= 1'b1;
    end else if (pop) begin
      hold_v_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) overrun_q <= 1'b0;
    else       overrun_q <= push & full & ~pop;
  end

  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
